// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the mantissa divide path.
//   - FSM state encoding of the sequential mantissa divider
//   - default operand / quotient geometry, shared with the mantissa multiplier
//   - saturation pattern returned on divide-by-zero and quotient overflow
// No ports: package only.
// -----------------------------------------------------------------------------
package div_pkg;

  // Default geometry: 24-bit mantissas in, Q1.31 quotient out.
  localparam int DEF_WIDTH_IN  = 24;
  localparam int DEF_WIDTH_OUT = 32;
  localparam int DEF_FRAC      = 31;

  // Saturation value. Kept wide so any quotient width up to 64 bits can
  // take its low slice.
  localparam logic [63:0] SAT_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/div_paso.sv
// -----------------------------------------------------------------------------
// div_paso
// One combinational restoring-division step: shift the next numerator bit into
// the partial remainder, trial-subtract the divisor and keep the difference
// when it does not go negative.
// Ports:
//   rem_i  partial remainder entering the step (always < div_i)
//   bit_i  next numerator bit, shifted into the remainder LSB
//   div_i  divisor
//   rem_o  partial remainder leaving the step (always < div_i)
//   q_o    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_paso
  import div_pkg::*;
#(
  parameter int WIDTH_IN = DEF_WIDTH_IN
) (
  input  logic [WIDTH_IN-1:0] rem_i,
  input  logic                bit_i,
  input  logic [WIDTH_IN-1:0] div_i,
  output logic [WIDTH_IN-1:0] rem_o,
  output logic                q_o
);

  // The shifted remainder needs one extra bit: rem_i < div_i < 2^WIDTH_IN,
  // so 2*rem_i + 1 < 2^(WIDTH_IN+1) and no carry is lost.
  logic [WIDTH_IN:0]   trial;
  logic [WIDTH_IN-1:0] diff;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, div_i});
    // When the subtraction is kept the true difference is below div_i, so the
    // modulo-2^WIDTH_IN difference of the low bits is already exact.
    diff  = trial[WIDTH_IN-1:0] - div_i;
    rem_o = q_o ? diff : trial[WIDTH_IN-1:0];
  end

endmodule : div_paso

// File: rtl/divisor_mantisa.sv
// -----------------------------------------------------------------------------
// divisor_mantisa
// Sequential restoring divider for floating-point mantissas. Computes
//   out = floor(in1 * 2^FRAC / in2)
// one quotient bit per clock, MSB first, as a Q(WIDTH_OUT-FRAC).FRAC value.
// Exponent handling and normalisation live outside this block.
//
// Optional feature (macro DIVISOR_MANTISA_STICKY_EN): adds the `sticky` output,
// set when the final remainder is non-zero (and on both saturating fast
// paths), for round-to-nearest-even downstream.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any operation in flight
//   start     operation request, only looked at while idle
//   in1/in2   dividend / divisor, captured on the accepting edge
//   out       quotient (all ones on divide-by-zero or overflow)
//   busy      high from the accepting edge until the block is idle again
//   done      one-cycle pulse; out and flags valid from this cycle on
//   div_zero  in2 was zero
//   ovf       true quotient does not fit in WIDTH_OUT bits
//   sticky    (optional) inexact result
// Timing: normal path done is high WIDTH_OUT+1 edges after the accepting edge,
// fast paths one edge after it. Results hold until the next accepted start.
// -----------------------------------------------------------------------------
module divisor_mantisa
  import div_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int FRAC      = DEF_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH_IN-1:0]  in1,
  input  logic [WIDTH_IN-1:0]  in2,
  output logic [WIDTH_OUT-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic                 ovf
`ifdef DIVISOR_MANTISA_STICKY_EN
  ,
  output logic                 sticky
`endif
);

  // Integer bits of the quotient. FRAC < WIDTH_OUT keeps this at least 1.
  localparam int INT_BITS = WIDTH_OUT - FRAC;
  localparam int CNT_W    = $clog2(WIDTH_OUT);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_OUT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0] out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;
  logic                 ovf_q, ovf_d;
`ifdef DIVISOR_MANTISA_STICKY_EN
  logic                 sticky_q, sticky_d;
`endif

  // Datapath registers: partial remainder, numerator bits still to be shifted
  // in (left-aligned), and the captured divisor.
  logic [WIDTH_IN-1:0]  rem_q, rem_d;
  logic [WIDTH_IN-1:0]  num_q, num_d;
  logic [WIDTH_IN-1:0]  dvs_q, dvs_d;

  // ---------------------------------------------------------------------------
  // Request classification (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic                         in2_zero;
  logic                         ovf_hit;
  logic [WIDTH_IN+INT_BITS-1:0] in1_ext;
  logic [WIDTH_IN+INT_BITS-1:0] ovf_limit;
  logic                         last_step;

  assign in2_zero  = (in2 == '0);
  // The quotient reaches 2^WIDTH_OUT exactly when in1 >= in2 * 2^INT_BITS.
  assign in1_ext   = {{INT_BITS{1'b0}}, in1};
  assign ovf_limit = {in2, {INT_BITS{1'b0}}};
  assign ovf_hit   = (in1_ext >= ovf_limit);
  assign last_step = (cnt_q == LAST_STEP);

  // ---------------------------------------------------------------------------
  // Single trial-subtract step, reused on every CALC cycle
  // ---------------------------------------------------------------------------
  logic [WIDTH_IN-1:0] step_rem;
  logic                step_bit;

  div_paso #(
    .WIDTH_IN (WIDTH_IN)
  ) u_paso (
    .rem_i (rem_q),
    .bit_i (num_q[WIDTH_IN-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state and control/result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef DIVISOR_MANTISA_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
`ifdef DIVISOR_MANTISA_STICKY_EN
      sticky_q   <= sticky_d;
`endif
    end
  end

  // NOTE: the datapath registers carry no reset; they are always reloaded on
  // the accepting edge before being read, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    num_q <= num_d;
    dvs_q <= dvs_d;
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (in2_zero || ovf_hit) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_step) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    out_d      = out_q;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    rem_d      = rem_q;
    num_d      = num_q;
    dvs_d      = dvs_q;
`ifdef DIVISOR_MANTISA_STICKY_EN
    sticky_d   = sticky_q;
`endif
    // done is registered from FIN, so it rises the edge after FIN is entered
    // and lasts exactly one cycle.
    done_d     = (state_q == ST_FIN);

    unique case (state_q)
      ST_IDLE: begin
        // busy falls on the first idle edge after the done pulse.
        busy_d = 1'b0;
        if (start) begin
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
`ifdef DIVISOR_MANTISA_STICKY_EN
          sticky_d   = 1'b0;
`endif
          if (in2_zero) begin
            // Zero divisor wins over overflow.
            out_d      = SAT_ONES[WIDTH_OUT-1:0];
            div_zero_d = 1'b1;
`ifdef DIVISOR_MANTISA_STICKY_EN
            sticky_d   = 1'b1;
`endif
          end else if (ovf_hit) begin
            out_d    = SAT_ONES[WIDTH_OUT-1:0];
            ovf_d    = 1'b1;
`ifdef DIVISOR_MANTISA_STICKY_EN
            sticky_d = 1'b1;
`endif
          end else begin
            // Numerator is in1 * 2^FRAC. Its bits above the quotient window
            // seed the remainder; the low INT_BITS of in1 are shifted in
            // first, followed by zeros.
            out_d = '0;
            cnt_d = '0;
            rem_d = in1 >> INT_BITS;
            num_d = in1 << (WIDTH_IN - INT_BITS);
            dvs_d = in2;
          end
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        num_d = {num_q[WIDTH_IN-2:0], 1'b0};
        out_d = {out_q[WIDTH_OUT-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
`ifdef DIVISOR_MANTISA_STICKY_EN
        if (last_step) begin
          sticky_d = (step_rem != '0);
        end
`endif
      end

      default: ;
    endcase
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;
`ifdef DIVISOR_MANTISA_STICKY_EN
  assign sticky   = sticky_q;
`endif

endmodule : divisor_mantisa

// File: doc/divisor_mantisa.md
Name: divisor_mantisa

Overview:
- Sequential restoring divider for 24-bit mantissas; the inverse operation of the team's combinational mantissa multiplier (24x24 -> 32).
- Produces a Q1.31 quotient one bit per clock.
- Feeds the floating-point divide path, where exponent subtraction and normalisation are handled outside this block.
- Start/done handshake; result held until the next operation is accepted.

Parameters:
- WIDTH_IN, 24: width of dividend and divisor.
- WIDTH_OUT, 32: width of the quotient.
- FRAC, 31: fractional bits of the quotient. The quotient is floor(in1 * 2^FRAC / in2). Constraint: FRAC < WIDTH_OUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- in1  in  WIDTH_IN  dividend; captured on the accepting edge.
- in2  in  WIDTH_IN  divisor; captured on the accepting edge.
- out  out  WIDTH_OUT  quotient, Q(WIDTH_OUT-FRAC).FRAC.
- busy  out  1  high from the accepting edge until the block returns to IDLE.
- done  out  1  one-cycle pulse; out and the flags are valid from this cycle.
- div_zero  out  1  in2 was 0.
- ovf  out  1  the true quotient does not fit in WIDTH_OUT bits.

Behaviour:
- Reset: on a rising edge with rst=1, the FSM goes to IDLE and out, busy, done, div_zero, ovf (and sticky) all become 0. Reset wins over every other event, aborts any operation in flight, and no done is produced for the aborted operation.
- FSM states: IDLE, CALC, FIN.
- IDLE -> CALC: start=1 on edge 0 with in2!=0 and no overflow. On that edge, in1/in2 are captured, busy=1, div_zero=0, ovf=0.
- IDLE -> FIN (fast path): start=1 with in2==0, or with in1 >= in2 << (WIDTH_OUT-FRAC).
  - Result: out = all ones; div_zero=1 (zero divisor) or ovf=1 (overflow); div_zero takes precedence if both apply.
  - done is high in the cycle after edge 1.
- CALC: exactly WIDTH_OUT edges, each producing one quotient bit, MSB first.
  - Initial partial remainder: in1 >> (WIDTH_OUT-FRAC).
  - Each step: shift in the next numerator bit (in1 bits first, then zeros); if the remainder >= in2, subtract and set the quotient bit to 1.
  - The remainder datapath is WIDTH_IN+1 bits wide, so no carry is lost.
- CALC -> FIN after the WIDTH_OUT-th step (edge WIDTH_OUT).
- FIN: done=1 for exactly one cycle, i.e. between edges WIDTH_OUT+1 and WIDTH_OUT+2 (33 and 34 at default). Next edge: FIN -> IDLE, done=0, busy=0.
- Latency: WIDTH_OUT+1 edges from the accepting edge to done high (normal path); 1 edge on the fast paths.
- Output holding: out and the flags hold their values after done until the next accepted start. Inputs need not be held after the accepting edge.
- start in CALC or FIN is ignored; no queueing. With start held high continuously, a new operation is accepted every WIDTH_OUT+2 edges.
- Result is exact truncation (round toward zero); no rounding is performed here.

Optional Feature:
- Macro: DIVISOR_MANTISA_STICKY_EN.
- With the macro defined: extra output sticky (out, 1 bit).
  - sticky = final remainder != 0, valid with done; cleared on reset and on an accepted start.
  - sticky = 1 on the div_zero and ovf fast paths.
  - Used for round-to-nearest-even in the FP divide path.
- Without the macro: the port is absent and no remainder-compare logic is built.

Decomposition:
- Shared package div_pkg holds:
  - FSM state encoding constants (IDLE, CALC, FIN);
  - default WIDTH_IN/WIDTH_OUT/FRAC constants, shared with the multiplier path;
  - the saturation constant (all ones).
- Sub-module div_paso is natural: a combinational single trial-subtract step (inputs remainder, next bit, divisor; outputs new remainder, quotient bit), instanced once in CALC.
- Bit counter, FSM and registers stay in divisor_mantisa.

Test Plan:
- in1=0x800000, in2=0x800000, start at edge 0 -> out=0x80000000, done high only after edge 33, div_zero=ovf=0, sticky=0.
- in1=0xC00000, in2=0x800000 -> out=0xC0000000, sticky=0. Then in1=0x800000, in2=0xC00000 -> out=0x55555555, sticky=1.
- in1=0x000001, in2=0x000003 -> out=0x2AAAAAAA, sticky=1, latency 33 edges.
- in2=0x000000 (any in1) -> done after edge 1, out=0xFFFFFFFF, div_zero=1, ovf=0. Then in1=0x800000, in2=0x400000 -> out=0xFFFFFFFF, ovf=1, div_zero=0.
- start pulses at edges 5 and 20 during CALC -> ignored, exactly one done.
- rst=1 at edge 10 mid-CALC -> busy=0 and out=0 after edge 10; no done. A new start at edge 12 completes normally after edge 45.
